// File: rtl/bcd_addsub_seq_if.sv
// Command/result bundle for the digit-serial signed BCD adder/subtractor.
// The master drives the operands and the start strobe; the slave returns the result.
interface bcd_addsub_seq_if #(
    parameter int DIGITS = 3
);
    logic                  start;
    logic                  op;
    logic                  a_sign;
    logic [4*DIGITS-1:0]   a_bcd;
    logic                  b_sign;
    logic [4*DIGITS-1:0]   b_bcd;
    logic                  ready;
    logic                  done;
    logic                  res_sign;
    logic [4*DIGITS-1:0]   res_bcd;
    logic                  ovf;
    logic                  err;

    modport master (
        output start, op, a_sign, a_bcd, b_sign, b_bcd,
        input  ready, done, res_sign, res_bcd, ovf, err
    );

    modport slave (
        input  start, op, a_sign, a_bcd, b_sign, b_bcd,
        output ready, done, res_sign, res_bcd, ovf, err
    );
endinterface

// File: rtl/bcd_addsub_seq.sv
// Digit-serial signed BCD add/subtract: one shared 9's-complement unit and digit adder, LSD first.
// Optional feature macro BCD_INVALID_CHECK_EN: reject operands containing digits above 9.
module bcd_addsub_seq #(
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_addsub_seq_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, P1, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_r, b_r, res_r;
    logic            sub_r, a_sign_r, sign_r, carry_r, ovf_r, err_r;
    logic [IW-1:0]   idx;
    logic [3:0]      x_dig, y_dig;
    logic [4:0]      sum;
    logic            last, accept;

    function automatic logic [3:0] nines(input logic [3:0] d, input logic en);
        nines = en ? 4'd9 - d : d;
    endfunction

    // Returns {carry_out, digit}; binary sums above 9 are corrected by +6.
    function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic c);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'd0, c};
        if (s > 5'd9) digit_add = {1'b1, 4'(s + 5'd6)};
        else          digit_add = {1'b0, s[3:0]};
    endfunction

`ifdef BCD_INVALID_CHECK_EN
    function automatic logic has_bad(input logic [W-1:0] v);
        has_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) has_bad = 1'b1;
    endfunction
    logic bad_start;
    assign bad_start = has_bad(bus.a_bcd) | has_bad(bus.b_bcd);
`else
    assign err_r = 1'b0;
`endif

    assign accept = (state == IDLE) && bus.start;
    assign last   = (idx == IW'(DIGITS - 1));

    always_comb begin
        x_dig = a_r[4*idx +: 4];
        y_dig = nines(b_r[4*idx +: 4], sub_r);
        if (state == FIX) begin
            x_dig = nines(res_r[4*idx +: 4], 1'b1);
            y_dig = 4'd0;
        end
        sum = digit_add(x_dig, y_dig, carry_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = P1;
            P1: begin
                if (err_r)                      state_nxt = DONE;
                else if (last && (!sub_r || sum[4])) state_nxt = DONE;
                else if (last)                  state_nxt = FIX;
            end
            FIX:  if (last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch: only meaningful after an accepted start, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= bus.a_bcd;
            b_r <= bus.b_bcd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r    <= '0;
            sub_r    <= 1'b0;
            a_sign_r <= 1'b0;
            sign_r   <= 1'b0;
            carry_r  <= 1'b0;
            ovf_r    <= 1'b0;
            idx      <= '0;
`ifdef BCD_INVALID_CHECK_EN
            err_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    sub_r    <= bus.a_sign ^ bus.b_sign ^ bus.op;
                    carry_r  <= bus.a_sign ^ bus.b_sign ^ bus.op;
                    a_sign_r <= bus.a_sign;
                    sign_r   <= 1'b0;
                    res_r    <= '0;
                    ovf_r    <= 1'b0;
                    idx      <= '0;
`ifdef BCD_INVALID_CHECK_EN
                    err_r    <= bad_start;
`endif
                end
                P1: if (!err_r) begin
                    res_r[4*idx +: 4] <= sum[3:0];
                    carry_r           <= sum[4];
                    idx               <= idx + 1'b1;
                    if (last) begin
                        if (!sub_r) begin
                            ovf_r  <= sum[4];
                            sign_r <= a_sign_r;
                        end else if (sum[4]) begin
                            sign_r <= a_sign_r;
                        end else begin
                            // Negative difference: result is in 10's complement, re-complement it.
                            sign_r  <= ~a_sign_r;
                            idx     <= '0;
                            carry_r <= 1'b1;
                        end
                    end
                end
                FIX: begin
                    res_r[4*idx +: 4] <= sum[3:0];
                    carry_r           <= sum[4];
                    idx               <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.done     = (state == DONE);
    assign bus.res_bcd  = res_r;
    assign bus.res_sign = sign_r & (|res_r);
    assign bus.ovf      = ovf_r;
    assign bus.err      = err_r;
endmodule

// File: doc/bcd_addsub_seq.md
# bcd_addsub_seq

Digit-serial sequencer for the signed BCD adder/subtractor. It accepts two sign-magnitude BCD operands and an add/subtract command. It time-shares one 9's-complement unit and one BCD digit adder across all digits, one digit per clock, least significant digit first. When a subtraction produces a negative result, it runs a second, re-complementing pass. It sits between the operand/command source and the result display/consumer and replaces the fully parallel per-digit adder chain.

## Interface
- DIGITS, default 3: number of BCD digits per operand. Each operand is 4*DIGITS bits wide.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; accepted only while ready=1.
- op  in  1  0 = A+B, 1 = A−B.
- a_sign  in  1  sign of A; 0 = positive, 1 = negative.
- a_bcd  in  4*DIGITS  magnitude of A; digit 0 is in bits [3:0].
- b_sign  in  1  sign of B.
- b_bcd  in  4*DIGITS  magnitude of B.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse; the result outputs are valid from this cycle.
- res_sign  out  1  result sign; zero is always reported as positive.
- res_bcd  out  4*DIGITS  result magnitude.
- ovf  out  1  magnitude carried out of the most significant digit (effective add only).
- err  out  1  an operand digit was greater than 9 (see Configuration).

## Operation
- The effective operation is subtraction when `a_sign ^ b_sign ^ op` = 1, otherwise addition.
- Digit adder, one digit per cycle:
  - s = x + y + c.
  - If s > 9: digit = s + 6 (low 4 bits), carry out = 1.
  - Otherwise: digit = s, carry out = 0.
- The 9's-complement unit outputs 9 − d when enabled and d unchanged when disabled.

States:
- IDLE: ready=1.
  - On start, latch the operands and the effective operation, clear the digit index and go to P1.
  - Carry-in is 1 for effective subtraction and 0 for effective addition.
- P1: one digit per cycle.
  - x = A digit; y = B digit, 9's-complemented if effective subtraction.
  - Write the sum digit into the result register and update the carry.
  - After digit DIGITS−1:
    - Effective add: ovf = final carry, res_sign = a_sign, go to DONE.
    - Effective sub with final carry = 1: result is the true magnitude, res_sign = a_sign, go to DONE.
    - Effective sub with final carry = 0: set res_sign = ~a_sign, reset the index, set carry = 1, go to FIX.
- FIX: one digit per cycle.
  - x = 9's complement of the result digit, y = 0.
  - Write the digit back into the result register.
  - After the last digit, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - If res_bcd is zero, res_sign is forced to 0.
- res_bcd, res_sign, ovf and err hold their values until the next accepted start. The start edge clears ovf and err.
- start is ignored while ready=0. There is no queueing.
- ovf is never set for effective subtraction.

## Timing
- Reset values: state IDLE, ready=1, done=0, res_sign=0, res_bcd=0, ovf=0, err=0.
- start is sampled at edge N. Digits are processed at edges N+1 … N+DIGITS.
- Without FIX, done is high in the cycle after edge N+DIGITS, so latency is DIGITS+1 cycles (4 for DIGITS=3).
- With FIX, done arrives DIGITS cycles later (7 for DIGITS=3).
- ready drops in the cycle after edge N and returns in the cycle after the done cycle. Back-to-back commands are therefore spaced at least DIGITS+2 cycles apart.
- Asserting rst_n low at any point, including mid-P1 or mid-FIX, aborts the operation immediately. All outputs take their reset values and no done is produced.

## Configuration
- BCD_INVALID_CHECK_EN defined:
  - On start, any operand digit greater than 9 sets err=1.
  - The block skips P1/FIX and goes directly to DONE with res_bcd=0 and res_sign=0 (done at edge N+1).
- Not defined:
  - err is tied to 0.
  - Invalid digits are processed as-is and the result is unspecified.

## Test plan
- +123 + +456 (op=0) -> res=+579, ovf=0, done 4 cycles after start.
- +500 − +123 (op=1) -> res=+377, no FIX pass, done after 4 cycles.
- +123 − +500 -> res=−377 (res_sign=1), FIX pass taken, done after 7 cycles. Also −123 + +500 -> +377.
- +999 + +001 -> res_bcd=000, ovf=1, res_sign=0. Also +250 − +250 -> +000 with res_sign=0.
- start pulsed during P1 -> ignored, and the first result is unchanged. rst_n pulsed low mid-FIX -> ready=1, done=0 and res_bcd=0 immediately, with no done afterwards.
- With BCD_INVALID_CHECK_EN: a_bcd=0x1A3 -> err=1, res=+000, done at the cycle after edge N+1. A following valid command clears err.
